// File: rtl/link_pair_sequencer.sv
// link_pair_sequencer
//   Power-up and link-check sequencer for the two TIA-568B pair channels.
//   Pair 1236 is powered and checked first, then pair 5478; the redirect
//   stages and LinkUp are enabled only once both pairs pass.  Failed checks
//   and link loss go through a bounded retry with backoff before a sticky
//   fault.
//
//   Ports:
//     Clock100MhzP  in   rising-edge clock
//     Reset         in   asynchronous, active-high reset
//     Enable        in   1 = run the sequence, 0 = shut down (clears fault)
//     Check1236     in   post-LNA link-good, pairs 1/2 and 3/6
//     Check5478     in   post-LNA link-good, pairs 5/4 and 7/8
//     PowerEn1236   out  supply enable, 1236 channel
//     PowerEn5478   out  supply enable, 5478 channel
//     Redirect1236  out  12-to-36 redirect stage enable
//     Redirect5478  out  54-to-78 redirect stage enable
//     LinkUp        out  both pairs up and redirecting
//     Fault         out  sticky fault flag
//     FaultCode     out  00 none, 01 pair 1236, 10 pair 5478, 11 link lost
//     RetryCount    out  retries consumed
//     LinkDrops     out  RUN exits due to check loss, saturating
//                        (present only when LINK_DROP_COUNT_EN is defined)
//
//   Optional feature macro: LINK_DROP_COUNT_EN
module link_pair_sequencer #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int CHECK_TIMEOUT = 4000,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       Clock100MhzP,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Check1236,
    input  logic       Check5478,
    output logic       PowerEn1236,
    output logic       PowerEn5478,
    output logic       Redirect1236,
    output logic       Redirect5478,
    output logic       LinkUp,
    output logic       Fault,
    output logic [1:0] FaultCode,
`ifdef LINK_DROP_COUNT_EN
    output logic [7:0] LinkDrops,
`endif
    output logic [1:0] RetryCount
);

    typedef enum logic [2:0] {
        IDLE, POWER_A, CHECK_A, POWER_B, CHECK_B, RUN, BACKOFF, FAULT
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CHECK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    state_t           state, nxt;
    logic [CNT_W-1:0] timer;
    logic             pass_q;   // check under test was high on the previous in-state edge
    logic             lowa_q;   // Check1236 was low on the previous in-state edge
    logic             lowb_q;   // Check5478 was low on the previous in-state edge
    logic             fail;
    logic [1:0]       fail_code;
    logic [1:0]       retry_nxt;
    logic [1:0]       code_nxt;
    logic             drop;

    always_comb begin
        nxt       = state;
        fail      = 1'b0;
        fail_code = 2'b00;
        retry_nxt = RetryCount;
        code_nxt  = FaultCode;
        drop      = 1'b0;
        if (!Enable) begin
            nxt       = IDLE;
            retry_nxt = '0;
            code_nxt  = '0;
        end else begin
            unique case (state)
                IDLE:    nxt = POWER_A;
                POWER_A: if (timer == SETTLE_LAST) nxt = CHECK_A;
                CHECK_A: begin
                    // a debounced pass on the timeout edge still counts as a pass
                    if (Check1236 && pass_q)        nxt = POWER_B;
                    else if (timer == TIMEOUT_LAST) begin fail = 1'b1; fail_code = 2'b01; end
                end
                POWER_B: if (timer == SETTLE_LAST) nxt = CHECK_B;
                CHECK_B: begin
                    // losing pair 1236 takes priority over promoting to RUN
                    if (!Check1236 && lowa_q)       begin fail = 1'b1; fail_code = 2'b01; end
                    else if (Check5478 && pass_q)   nxt = RUN;
                    else if (timer == TIMEOUT_LAST) begin fail = 1'b1; fail_code = 2'b10; end
                end
                RUN: begin
                    if ((!Check1236 && lowa_q) || (!Check5478 && lowb_q)) begin
                        fail      = 1'b1;
                        fail_code = 2'b11;
                        drop      = 1'b1;
                    end
                end
                BACKOFF: if (timer == SETTLE_LAST) nxt = POWER_A;
                FAULT:   nxt = FAULT;
                default: nxt = IDLE;
            endcase
            if (fail) begin
                if (RetryCount < RETRY_LIMIT) begin
                    retry_nxt = RetryCount + 2'd1;
                    nxt       = BACKOFF;
                end else begin
                    nxt      = FAULT;
                    code_nxt = fail_code;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge Clock100MhzP or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            timer        <= '0;
            pass_q       <= 1'b0;
            lowa_q       <= 1'b0;
            lowb_q       <= 1'b0;
            PowerEn1236  <= 1'b0;
            PowerEn5478  <= 1'b0;
            Redirect1236 <= 1'b0;
            Redirect5478 <= 1'b0;
            LinkUp       <= 1'b0;
            Fault        <= 1'b0;
            FaultCode    <= '0;
            RetryCount   <= '0;
        end else begin
            state      <= nxt;
            RetryCount <= retry_nxt;
            FaultCode  <= code_nxt;
            if (nxt != state) begin
                timer  <= '0;
                pass_q <= 1'b0;
                lowa_q <= 1'b0;
                lowb_q <= 1'b0;
            end else begin
                if (timer != '1) timer <= timer + 1'b1;
                pass_q <= (state == CHECK_B) ? Check5478 : Check1236;
                lowa_q <= !Check1236;
                lowb_q <= !Check5478;
            end
            PowerEn1236  <= (nxt == POWER_A) || (nxt == CHECK_A) || (nxt == POWER_B) ||
                            (nxt == CHECK_B) || (nxt == RUN);
            PowerEn5478  <= (nxt == POWER_B) || (nxt == CHECK_B) || (nxt == RUN);
            Redirect1236 <= (nxt == RUN);
            Redirect5478 <= (nxt == RUN);
            LinkUp       <= (nxt == RUN);
            Fault        <= (nxt == FAULT);
        end
    end

`ifdef LINK_DROP_COUNT_EN
    always_ff @(posedge Clock100MhzP or posedge Reset) begin
        if (Reset)                          LinkDrops <= '0;
        else if (!Enable)                   LinkDrops <= '0;
        else if (drop && (LinkDrops != '1)) LinkDrops <= LinkDrops + 8'd1;
    end
`endif

endmodule

// File: tb/tb_link_pair_sequencer.sv
module tb_link_pair_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 8;
    localparam int MAXR    = 2;

    logic Clock100MhzP = 1'b0;
    logic Reset = 1'b1, Enable = 1'b0, Check1236 = 1'b0, Check5478 = 1'b0;
    logic PowerEn1236, PowerEn5478, Redirect1236, Redirect5478, LinkUp, Fault;
    logic [1:0] FaultCode, RetryCount;
`ifdef LINK_DROP_COUNT_EN
    logic [7:0] LinkDrops;
`endif

    int ncmp = 0;
    int nfail = 0;

    always #5 Clock100MhzP = ~Clock100MhzP;

    link_pair_sequencer #(
        .SETTLE_CYCLES(SETTLE), .CHECK_TIMEOUT(TIMEOUT), .MAX_RETRIES(MAXR), .CNT_W(16)
    ) dut (
        .Clock100MhzP(Clock100MhzP), .Reset(Reset), .Enable(Enable),
        .Check1236(Check1236), .Check5478(Check5478),
        .PowerEn1236(PowerEn1236), .PowerEn5478(PowerEn5478),
        .Redirect1236(Redirect1236), .Redirect5478(Redirect5478),
        .LinkUp(LinkUp), .Fault(Fault), .FaultCode(FaultCode),
`ifdef LINK_DROP_COUNT_EN
        .LinkDrops(LinkDrops),
`endif
        .RetryCount(RetryCount)
    );

    // Reference model: phases with elapsed-cycle age and run lengths of
    // consecutive high/low samples, advanced once per rising edge.
    typedef enum int {M_IDLE, M_PWRA, M_CHKA, M_PWRB, M_CHKB, M_RUN, M_BACK, M_FLT} mph_t;
    mph_t ph = M_IDLE;
    int age = 0, hia = 0, hib = 0, loa = 0, lob = 0;
    int retries = 0, code = 0, drops = 0;

    task automatic model_reset();
        ph = M_IDLE; age = 0; hia = 0; hib = 0; loa = 0; lob = 0;
        retries = 0; code = 0; drops = 0;
    endtask

    task automatic model_step(input bit en, input bit ca, input bit cb);
        mph_t nph;
        int fc;
        nph = ph; fc = 0;
        age++;
        hia = ca ? hia + 1 : 0;  loa = ca ? 0 : loa + 1;
        hib = cb ? hib + 1 : 0;  lob = cb ? 0 : lob + 1;
        if (!en) begin
            nph = M_IDLE; retries = 0; code = 0; drops = 0;
        end else begin
            case (ph)
                M_IDLE: nph = M_PWRA;
                M_PWRA: if (age == SETTLE) nph = M_CHKA;
                M_CHKA: if (hia >= 2) nph = M_PWRB; else if (age == TIMEOUT) fc = 1;
                M_PWRB: if (age == SETTLE) nph = M_CHKB;
                M_CHKB: if (loa >= 2) fc = 1; else if (hib >= 2) nph = M_RUN;
                        else if (age == TIMEOUT) fc = 2;
                M_RUN:  if (loa >= 2 || lob >= 2) begin
                            fc = 3;
                            if (drops < 255) drops++;
                        end
                M_BACK: if (age == SETTLE) nph = M_PWRA;
                default: nph = ph;
            endcase
            if (fc != 0) begin
                if (retries < MAXR) begin retries++; nph = M_BACK; end
                else begin nph = M_FLT; code = fc; end
            end
        end
        if (nph != ph) begin age = 0; hia = 0; hib = 0; loa = 0; lob = 0; end
        ph = nph;
    endtask

    function automatic logic [9:0] model_out();
        bit pa, pb, up;
        pa = (ph == M_PWRA || ph == M_CHKA || ph == M_PWRB || ph == M_CHKB || ph == M_RUN);
        pb = (ph == M_PWRB || ph == M_CHKB || ph == M_RUN);
        up = (ph == M_RUN);
        return {pa, pb, up, up, up, (ph == M_FLT), 2'(code), 2'(retries)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk(tag, 32'({PowerEn1236, PowerEn5478, Redirect1236, Redirect5478, LinkUp,
                      Fault, FaultCode, RetryCount}), 32'(model_out()));
`ifdef LINK_DROP_COUNT_EN
        chk({tag, "_drops"}, 32'(LinkDrops), 32'(drops));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic cyc(input bit en, input bit ca, input bit cb, input string tag);
        Enable = en; Check1236 = ca; Check5478 = cb;
        @(posedge Clock100MhzP);
        model_step(en, ca, cb);
        #1;
        chk_all(tag);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge Clock100MhzP);
        #1;
        model_reset();
        chk_all("reset");
        Reset = 1'b0;

        // nominal bring-up: edge numbering starts at the first edge sampling Enable=1
        for (int e = 1; e <= 15; e++) begin
            cyc(1, 1, 1, "nominal");
            if (e == 1)  chk("pwr1236_e1", 32'(PowerEn1236), 32'd1);
            if (e == 6)  chk("pwr5478_e6", 32'(PowerEn5478), 32'd0);
            if (e == 7)  chk("pwr5478_e7", 32'(PowerEn5478), 32'd1);
            if (e == 12) chk("linkup_e12", 32'(LinkUp), 32'd0);
            if (e == 13) chk("linkup_e13", 32'(LinkUp), 32'd1);
        end

        // single-cycle glitch is filtered
        cyc(1, 0, 1, "glitch");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, "glitch_after");
        chk("glitch_linkup", 32'(LinkUp), 32'd1);

        // two-cycle loss, then recovery; repeated until escalation to fault code 11
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 1, "loss");
            cyc(1, 0, 1, "loss");
            chk("loss_linkup", 32'(LinkUp), 32'd0);
            if (k < 3) begin
                chk("loss_retry", 32'(RetryCount), 32'(k));
                for (int i = 1; i <= 16; i++) begin
                    cyc(1, 1, 1, "recover");
                    if (i == 15) chk("recover_e15", 32'(LinkUp), 32'd0);
                    if (i == 16) chk("recover_e16", 32'(LinkUp), 32'd1);
                end
            end
        end
        chk("flap_fault", 32'({Fault, FaultCode}), 32'b111);

        // Enable=0 during FAULT
        cyc(0, 1, 1, "dis_fault");
        chk("dis_fault_zero", 32'({PowerEn1236, PowerEn5478, LinkUp, Fault, FaultCode, RetryCount}), 32'd0);

        // pair A never passes
        for (int e = 1; e <= 45; e++) begin
            cyc(1, 0, 1, "pair_a_dead");
            if (e == 13) chk("pa_retry1", 32'(RetryCount), 32'd1);
            if (e == 29) chk("pa_retry2", 32'(RetryCount), 32'd2);
        end
        chk("pa_fault", 32'({Fault, FaultCode, PowerEn1236, PowerEn5478}), 32'b10100);
        cyc(0, 1, 1, "dis_pa");

        // debounce: alternating Check5478 never passes in CHECK_B
        for (int e = 1; e <= 19; e++) cyc(1, 1, e[0], "debounce");
        chk("debounce_retry", 32'({RetryCount, PowerEn5478}), 32'b010);
        cyc(0, 1, 1, "dis_db");

        // Enable=0 mid-POWER_B
        for (int e = 1; e <= 9; e++) cyc(1, 1, 1, "to_pwrb");
        chk("in_pwrb", 32'(PowerEn5478), 32'd1);
        cyc(0, 1, 1, "dis_pwrb");
        chk("dis_pwrb_zero", 32'({PowerEn1236, PowerEn5478, RetryCount, FaultCode}), 32'd0);

        // asynchronous reset mid-CHECK_A
        for (int e = 1; e <= 6; e++) cyc(1, 1, 0, "to_chka");
        chk("in_chka", 32'(PowerEn1236), 32'd1);
        #2 Reset = 1'b1;
        #1 chk("async_reset", 32'({PowerEn1236, PowerEn5478, LinkUp, Fault, RetryCount}), 32'd0);
        @(posedge Clock100MhzP);
        #1 Reset = 1'b0;
        model_reset();

        // randomized soak against the model
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 149) != 0, $urandom_range(0, 11) != 0,
                $urandom_range(0, 11) != 0, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
